// File: rtl/collision_sweep.sv
// collision_sweep: walks every point through every obstacle edge on one shared collision unit.
// Define COLLISION_TIMEOUT_EN to bound each collision wait with a TIMEOUT_CYCLES watchdog.
module collision_sweep #(
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int MAX_POINTS = 64,
  parameter int MAX_VERTS = 16,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int PA = $clog2(MAX_POINTS),
  localparam int VA = $clog2(MAX_VERTS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start,
  input  logic [PA:0]              num_points,
  input  logic [VA:0]              num_verts,
  output logic [PA-1:0]            pt_rd_addr,
  input  logic [POSITION_SIZE-1:0] pt_pos_x,
  input  logic [POSITION_SIZE-1:0] pt_pos_y,
  input  logic [POSITION_SIZE-1:0] pt_dx,
  input  logic [POSITION_SIZE-1:0] pt_dy,
  input  logic [VELOCITY_SIZE-1:0] pt_vel_x,
  input  logic [VELOCITY_SIZE-1:0] pt_vel_y,
  output logic                     pt_wr_en,
  output logic [PA-1:0]            pt_wr_addr,
  output logic [POSITION_SIZE-1:0] pt_wr_x,
  output logic [POSITION_SIZE-1:0] pt_wr_y,
  output logic [VELOCITY_SIZE-1:0] pt_wr_vx,
  output logic [VELOCITY_SIZE-1:0] pt_wr_vy,
  output logic [VA-1:0]            vt_rd_addr,
  input  logic [POSITION_SIZE-1:0] vt_x,
  input  logic [POSITION_SIZE-1:0] vt_y,
  output logic                     col_valid_out,
  output logic [POSITION_SIZE-1:0] col_v1_x,
  output logic [POSITION_SIZE-1:0] col_v1_y,
  output logic [POSITION_SIZE-1:0] col_v2_x,
  output logic [POSITION_SIZE-1:0] col_v2_y,
  output logic [POSITION_SIZE-1:0] col_pos_x,
  output logic [POSITION_SIZE-1:0] col_pos_y,
  output logic [POSITION_SIZE-1:0] col_dx,
  output logic [POSITION_SIZE-1:0] col_dy,
  output logic [VELOCITY_SIZE-1:0] col_vel_x,
  output logic [VELOCITY_SIZE-1:0] col_vel_y,
  input  logic                     col_valid_in,
  input  logic                     col_hit,
  input  logic [POSITION_SIZE-1:0] col_x_new,
  input  logic [POSITION_SIZE-1:0] col_y_new,
  input  logic [VELOCITY_SIZE-1:0] col_vx_new,
  input  logic [VELOCITY_SIZE-1:0] col_vy_new,
  output logic                     busy,
  output logic                     done,
  output logic [PA:0]              hit_count,
  output logic                     timeout_flag
);
  typedef enum logic [3:0] {
    IDLE, PT_ADDR, PT_CAP, V0_ADDR, V0_CAP, VN_ADDR, VN_CAP, ISSUE, WAIT, WRITE, DONE
  } state_t;
  state_t state, nxt;
  logic [PA:0] np;
  logic [VA:0] nv;
  logic [PA-1:0] p;
  logic [VA-1:0] e;
  logic [POSITION_SIZE-1:0] pos_x, pos_y, d_x, d_y, first_x, first_y, prev_x, prev_y, cur_x, cur_y;
  logic [POSITION_SIZE-1:0] res_x, res_y;
  logic [VELOCITY_SIZE-1:0] vel_x, vel_y, res_vx, res_vy;
  logic hit, last_pt, last_e, got_hit, advance, expire;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end
  assign last_pt = {1'b0, p} == np - 1'b1;
  assign last_e = {1'b0, e} == nv - 1'b1;
  assign got_hit = state == WAIT && col_valid_in && col_hit;
  assign advance = (state == WAIT && col_valid_in && !col_hit) || expire;
`ifdef COLLISION_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt;
  assign expire = state == WAIT && !col_valid_in && wcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wcnt <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      if (state == IDLE && start) timeout_flag <= 1'b0;
      else if (expire) timeout_flag <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign timeout_flag = 1'b0;
`endif
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = num_points == '0 ? DONE : PT_ADDR;
      PT_ADDR: nxt = PT_CAP;
      PT_CAP:  nxt = nv < 2 ? WRITE : V0_ADDR;
      V0_ADDR: nxt = V0_CAP;
      V0_CAP:  nxt = VN_ADDR;
      VN_ADDR: nxt = VN_CAP;
      VN_CAP:  nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = got_hit ? WRITE : advance ? (last_e ? WRITE : VN_ADDR) : WAIT;
      WRITE:   nxt = last_pt ? DONE : PT_ADDR;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      {np, nv, p, e, hit, hit_count} <= '0;
      {pos_x, pos_y, d_x, d_y, vel_x, vel_y} <= '0;
      {first_x, first_y, prev_x, prev_y, cur_x, cur_y} <= '0;
      {res_x, res_y, res_vx, res_vy} <= '0;
    end else begin
      if (state == IDLE && start) begin
        np <= num_points;
        nv <= num_verts;
        p <= '0;
        hit_count <= '0;
      end
      if (state == PT_CAP) begin
        {pos_x, pos_y, d_x, d_y} <= {pt_pos_x, pt_pos_y, pt_dx, pt_dy};
        {vel_x, vel_y} <= {pt_vel_x, pt_vel_y};
        hit <= 1'b0;
      end
      if (state == V0_CAP) begin
        {first_x, first_y, prev_x, prev_y} <= {vt_x, vt_y, vt_x, vt_y};
        e <= '0;
      end
      // The closing edge reuses the cached vertex 0; its RAM read is discarded.
      if (state == VN_CAP) {cur_x, cur_y} <= last_e ? {first_x, first_y} : {vt_x, vt_y};
      if (got_hit) begin
        {res_x, res_y, res_vx, res_vy} <= {col_x_new, col_y_new, col_vx_new, col_vy_new};
        hit <= 1'b1;
        hit_count <= hit_count + 1'b1;
      end
      if (advance) begin
        {prev_x, prev_y} <= {cur_x, cur_y};
        e <= e + 1'b1;
      end
      if (state == WRITE) p <= p + 1'b1;
    end
  end
  assign pt_rd_addr = p;
  assign vt_rd_addr = state == VN_ADDR && !last_e ? e + 1'b1 : '0;
  assign col_valid_out = state == ISSUE;
  assign {col_v1_x, col_v1_y, col_v2_x, col_v2_y} = {prev_x, prev_y, cur_x, cur_y};
  assign {col_pos_x, col_pos_y, col_dx, col_dy} = {pos_x, pos_y, d_x, d_y};
  assign {col_vel_x, col_vel_y} = {vel_x, vel_y};
  assign pt_wr_en = state == WRITE;
  assign pt_wr_addr = p;
  assign pt_wr_x = hit ? res_x : pos_x + d_x;
  assign pt_wr_y = hit ? res_y : pos_y + d_y;
  assign pt_wr_vx = hit ? res_vx : vel_x;
  assign pt_wr_vy = hit ? res_vy : vel_y;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
endmodule

// File: tb/tb_collision_sweep.sv
// tb_collision_sweep: random and directed sweeps checked against a per-point reference model.
module tb_collision_sweep;
  logic clk_in = 1'b0, rst_in = 1'b1, start = 1'b0;
  logic [6:0] num_points = '0;
  logic [4:0] num_verts = '0;
  logic [5:0] pt_rd_addr, pt_wr_addr;
  logic [3:0] vt_rd_addr;
  logic signed [7:0] pt_pos_x, pt_pos_y, pt_dx, pt_dy, pt_vel_x, pt_vel_y, vt_x, vt_y;
  logic signed [7:0] pt_wr_x, pt_wr_y, pt_wr_vx, pt_wr_vy;
  logic signed [7:0] col_v1_x, col_v1_y, col_v2_x, col_v2_y, col_pos_x, col_pos_y, col_dx, col_dy;
  logic signed [7:0] col_vel_x, col_vel_y;
  logic signed [7:0] col_x_new = '0, col_y_new = '0, col_vx_new = '0, col_vy_new = '0;
  logic col_valid_out, col_valid_in = 1'b0, col_hit = 1'b0;
  logic pt_wr_en, busy, done, timeout_flag;
  logic [6:0] hit_count;

  collision_sweep #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .num_points(num_points), .num_verts(num_verts),
    .pt_rd_addr(pt_rd_addr), .pt_pos_x(pt_pos_x), .pt_pos_y(pt_pos_y), .pt_dx(pt_dx), .pt_dy(pt_dy),
    .pt_vel_x(pt_vel_x), .pt_vel_y(pt_vel_y), .pt_wr_en(pt_wr_en), .pt_wr_addr(pt_wr_addr),
    .pt_wr_x(pt_wr_x), .pt_wr_y(pt_wr_y), .pt_wr_vx(pt_wr_vx), .pt_wr_vy(pt_wr_vy),
    .vt_rd_addr(vt_rd_addr), .vt_x(vt_x), .vt_y(vt_y), .col_valid_out(col_valid_out),
    .col_v1_x(col_v1_x), .col_v1_y(col_v1_y), .col_v2_x(col_v2_x), .col_v2_y(col_v2_y),
    .col_pos_x(col_pos_x), .col_pos_y(col_pos_y), .col_dx(col_dx), .col_dy(col_dy),
    .col_vel_x(col_vel_x), .col_vel_y(col_vel_y), .col_valid_in(col_valid_in), .col_hit(col_hit),
    .col_x_new(col_x_new), .col_y_new(col_y_new), .col_vx_new(col_vx_new), .col_vy_new(col_vy_new),
    .busy(busy), .done(done), .hit_count(hit_count), .timeout_flag(timeout_flag)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int pidx; logic [79:0] ops; } req_t;
  typedef struct { logic [5:0] addr; logic [31:0] data; } wr_t;
  logic signed [7:0] pmem_x [64], pmem_y [64], pmem_dx [64], pmem_dy [64], pmem_vx [64], pmem_vy [64];
  logic signed [7:0] vmem_x [16], vmem_y [16];
  logic signed [7:0] rx [64], ry [64], rvx [64], rvy [64];
  int hit_edge [64];
  req_t rq [$];
  wr_t wq [$];
  int total = 0, bad = 0;
  int done_cnt = 0, busy_cyc = 0, lat_sum = 0, cur_nv = 0, lat_lo = 1, lat_hi = 3;
  bit silent = 1'b0, busy_after, ok;
  logic [6:0] hc_after;

  always @(posedge clk_in) begin
    {pt_pos_x, pt_pos_y, pt_dx, pt_dy} <= {pmem_x[pt_rd_addr], pmem_y[pt_rd_addr], pmem_dx[pt_rd_addr], pmem_dy[pt_rd_addr]};
    {pt_vel_x, pt_vel_y} <= {pmem_vx[pt_rd_addr], pmem_vy[pt_rd_addr]};
    {vt_x, vt_y} <= {vmem_x[vt_rd_addr], vmem_y[vt_rd_addr]};
  end

  always @(negedge clk_in) begin
    if (pt_wr_en) wq.push_back('{pt_wr_addr, {pt_wr_x, pt_wr_y, pt_wr_vx, pt_wr_vy}});
    if (done) done_cnt++;
    if (busy) busy_cyc++;
  end

  // Collision unit stand-in: identifies the edge by its first vertex, answers after a random latency.
  always begin
    @(negedge clk_in);
    if (col_valid_out && !silent) begin
      int pi, eid, l;
      pi = wq.size();
      eid = -1;
      for (int i = 0; i < cur_nv; i++) if ({vmem_x[i], vmem_y[i]} == {col_v1_x, col_v1_y}) eid = i;
      rq.push_back('{pi, {col_v1_x, col_v1_y, col_v2_x, col_v2_y, col_pos_x, col_pos_y, col_dx, col_dy, col_vel_x, col_vel_y}});
      l = $urandom_range(lat_lo, lat_hi);
      lat_sum += l;
      repeat (l) @(negedge clk_in);
      col_valid_in = 1'b1;
      col_hit = eid >= 0 && eid == hit_edge[pi];
      {col_x_new, col_y_new, col_vx_new, col_vy_new} = {rx[pi], ry[pi], rvx[pi], rvy[pi]};
      @(negedge clk_in);
      col_valid_in = 1'b0;
      col_hit = 1'b0;
    end
  end

  task automatic fill(input int nv);
    for (int p = 0; p < 64; p++) begin
      {pmem_x[p], pmem_y[p], pmem_dx[p], pmem_dy[p]} = $urandom;
      {pmem_vx[p], pmem_vy[p], rx[p], ry[p]} = $urandom;
      {rvx[p], rvy[p]} = 16'($urandom);
      hit_edge[p] = int'($urandom_range(0, nv)) - 1;
    end
    for (int i = 0; i < 16; i++) begin
      vmem_x[i] = 8'(i * 9 - 70 + int'($urandom_range(0, 3)));
      vmem_y[i] = 8'($urandom);
    end
  endtask

  task automatic run_sweep(input int np, input int nv, input bit poke, output bit seen);
    rq.delete(); wq.delete();
    done_cnt = 0; busy_cyc = 0; lat_sum = 0; cur_nv = nv;
    num_points = 7'(np); num_verts = 5'(nv);
    @(negedge clk_in) start = 1'b1;
    @(negedge clk_in) start = 1'b0;
    busy_after = busy; hc_after = hit_count; seen = done;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk_in);
      start = poke && i == 10;
      seen = done;
    end
    start = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    total++; if ({busy, done, pt_wr_en, col_valid_out} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, pt_wr_en, col_valid_out}); end
    total++; if (hit_count !== 7'd0) begin bad++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_timeout got %b want 0", timeout_flag); end
    total++; if ({pt_rd_addr, pt_wr_addr, vt_rd_addr, pt_wr_x, pt_wr_y, col_v1_x, col_pos_x, col_vel_x} !== '0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", {pt_rd_addr, pt_wr_addr, vt_rd_addr, pt_wr_x, pt_wr_y, col_v1_x, col_pos_x, col_vel_x}); end
  endtask

  task automatic square(input logic signed [7:0] dy);
    {vmem_x[0], vmem_y[0], vmem_x[1], vmem_y[1]} = {8'sd0, 8'sd0, 8'sd40, 8'sd0};
    {vmem_x[2], vmem_y[2], vmem_x[3], vmem_y[3]} = {8'sd40, 8'sd40, 8'sd0, 8'sd40};
    {pmem_x[0], pmem_y[0], pmem_dx[0], pmem_dy[0], pmem_vx[0], pmem_vy[0]} = {8'sd10, 8'sd10, 8'sd0, dy, 8'sd1, 8'sd2};
  endtask

  task automatic test_direct_hit();
    fill(4); square(-8'sd20);
    hit_edge[0] = 0;
    {rx[0], ry[0], rvx[0], rvy[0]} = {8'sd10, 8'sd2, 8'sd3, -8'sd4};
    run_sweep(1, 4, 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL hit_done got none want pulse"); end
    total++; if (busy_after !== 1'b1) begin bad++; $display("FAIL hit_busy_rise got %b want 1", busy_after); end
    total++; if (rq.size() !== 1) begin bad++; $display("FAIL hit_requests got %0d want 1", rq.size()); end
    total++; if (wq.size() !== 1 || wq[0].addr !== 6'd0 || wq[0].data !== 32'h0A02_03FC) begin
      bad++; $display("FAIL hit_write got n=%0d %h want 1 0a0203fc", wq.size(), wq.size() ? wq[0].data : 32'h0); end
    total++; if (hit_count !== 7'd1) begin bad++; $display("FAIL hit_count got %0d want 1", hit_count); end
    total++; if (busy_cyc !== 8 + lat_sum) begin bad++; $display("FAIL hit_cycles got %0d want %0d", busy_cyc, 8 + lat_sum); end
  endtask

  task automatic test_wrap();
    fill(4); square(8'sd5);
    hit_edge[0] = -1;
    run_sweep(1, 4, 0, ok);
    total++; if (hc_after !== 7'd0) begin bad++; $display("FAIL wrap_hit_clear got %0d want 0", hc_after); end
    total++; if (rq.size() !== 4) begin bad++; $display("FAIL wrap_requests got %0d want 4", rq.size()); end
    else begin total++; if (rq[3].ops[79:48] !== 32'h0028_0000) begin bad++; $display("FAIL wrap_edge got %h want 00280000", rq[3].ops[79:48]); end end
    total++; if (wq.size() !== 1 || wq[0].data !== 32'h0A0F_0102) begin
      bad++; $display("FAIL wrap_write got n=%0d %h want 0a0f0102", wq.size(), wq.size() ? wq[0].data : 32'h0); end
    total++; if (hit_count !== 7'd0) begin bad++; $display("FAIL wrap_hit_count got %0d want 0", hit_count); end
  endtask

  task automatic test_three_points();
    fill(4);
    hit_edge[0] = -1; hit_edge[1] = 1; hit_edge[2] = -1;
    run_sweep(3, 4, 0, ok);
    total++; if (rq.size() !== 10) begin bad++; $display("FAIL three_requests got %0d want 10", rq.size()); end
    else begin total++; if (rq[5].pidx !== 1 || rq[6].pidx !== 2) begin bad++; $display("FAIL three_stop got %0d,%0d want 1,2", rq[5].pidx, rq[6].pidx); end end
    total++; if (wq.size() !== 3) begin bad++; $display("FAIL three_writes got %0d want 3", wq.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (wq[i].addr !== 6'(i)) begin bad++; $display("FAIL three_addr got %0d want %0d", wq[i].addr, i); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL three_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_few_verts();
    fill(1);
    {pmem_x[0], pmem_dx[0]} = {8'sd127, 8'sd1};
    run_sweep(2, 1, 0, ok);
    total++; if (rq.size() !== 0) begin bad++; $display("FAIL fewv_requests got %0d want 0", rq.size()); end
    total++; if (wq.size() !== 2) begin bad++; $display("FAIL fewv_writes got %0d want 2", wq.size()); end
    else for (int p = 0; p < 2; p++) begin
      logic signed [7:0] ex, ey;
      ex = pmem_x[p] + pmem_dx[p]; ey = pmem_y[p] + pmem_dy[p];
      total++; if (wq[p].data !== {ex, ey, pmem_vx[p], pmem_vy[p]}) begin
        bad++; $display("FAIL fewv_write%0d got %h want %h", p, wq[p].data, {ex, ey, pmem_vx[p], pmem_vy[p]}); end
    end
    total++; if (wq.size() > 0 && wq[0].data[31:24] !== 8'h80) begin bad++; $display("FAIL fewv_wrap got %h want 80", wq[0].data[31:24]); end
  endtask

  task automatic test_zero_points();
    run_sweep(0, 4, 0, ok);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done got %0d want 1", done_cnt); end
    total++; if (wq.size() !== 0 || busy_cyc !== 0) begin bad++; $display("FAIL zero_activity got w=%0d b=%0d want 0 0", wq.size(), busy_cyc); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int np, nv, idx, ehits, ecyc;
      np = $urandom_range(1, 7); nv = $urandom_range(2, 6);
      lat_lo = 1; lat_hi = 4;
      fill(nv);
      run_sweep(np, nv, it == 3, ok);
      idx = 0; ehits = 0; ecyc = 0;
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_done got none want pulse", it); end
      for (int p = 0; p < np; p++) begin
        int k, nreq;
        logic signed [7:0] ex, ey;
        logic [31:0] ed;
        k = hit_edge[p]; nreq = k < 0 ? nv : k + 1;
        ehits += k >= 0; ecyc += 5 + 3 * nreq;
        ex = pmem_x[p] + pmem_dx[p]; ey = pmem_y[p] + pmem_dy[p];
        ed = k >= 0 ? {rx[p], ry[p], rvx[p], rvy[p]} : {ex, ey, pmem_vx[p], pmem_vy[p]};
        total++; if (p >= wq.size() || wq[p].addr !== 6'(p) || wq[p].data !== ed) begin
          bad++; $display("FAIL rand%0d_write%0d got %h want %h", it, p, p < wq.size() ? {2'b0, wq[p].addr, wq[p].data} : 40'h0, {8'(p), ed}); end
        for (int e = 0; e < nreq; e++) begin
          logic [79:0] eo;
          eo = {vmem_x[e], vmem_y[e], vmem_x[(e + 1) % nv], vmem_y[(e + 1) % nv],
                pmem_x[p], pmem_y[p], pmem_dx[p], pmem_dy[p], pmem_vx[p], pmem_vy[p]};
          total++; if (idx >= rq.size() || rq[idx].pidx !== p || rq[idx].ops !== eo) begin
            bad++; $display("FAIL rand%0d_req%0d got %h want %h", it, idx, idx < rq.size() ? rq[idx].ops : 80'h0, eo); end
          idx++;
        end
      end
      total++; if (rq.size() !== idx) begin bad++; $display("FAIL rand%0d_nreq got %0d want %0d", it, rq.size(), idx); end
      total++; if (hit_count !== 7'(ehits)) begin bad++; $display("FAIL rand%0d_hits got %0d want %0d", it, hit_count, ehits); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL rand%0d_done_cnt got %0d want 1", it, done_cnt); end
      total++; if (busy_cyc !== ecyc + lat_sum) begin bad++; $display("FAIL rand%0d_cycles got %0d want %0d", it, busy_cyc, ecyc + lat_sum); end
    end
`ifndef COLLISION_TIMEOUT_EN
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL rand_timeout_tied got %b want 0", timeout_flag); end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic signed [7:0] ex, ey;
    fill(4);
    silent = 1'b1; cur_nv = 4;
    num_points = 7'd2; num_verts = 5'd4;
    @(negedge clk_in) start = 1'b1;
    @(negedge clk_in) start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk_in); seen = col_valid_out; end
    total++; if (!seen) begin bad++; $display("FAIL rmid_issue got none want request"); end
    @(negedge clk_in);
    wq.delete(); done_cnt = 0;
    rst_in = 1'b1;
    @(negedge clk_in) rst_in = 1'b0;
    {col_valid_in, col_hit} = 2'b11;
    @(negedge clk_in) {col_valid_in, col_hit} = 2'b00;
    repeat (4) @(negedge clk_in);
    total++; if (wq.size() !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_quiet got w=%0d d=%0d b=%b want 0 0 0", wq.size(), done_cnt, busy); end
    silent = 1'b0;
    hit_edge[0] = -1; hit_edge[1] = 2;
    run_sweep(2, 4, 0, ok);
    ex = pmem_x[0] + pmem_dx[0]; ey = pmem_y[0] + pmem_dy[0];
    total++; if (wq.size() !== 2 || wq[0].data !== {ex, ey, pmem_vx[0], pmem_vy[0]} || wq[1].data !== {rx[1], ry[1], rvx[1], rvy[1]}) begin
      bad++; $display("FAIL rmid_clean got n=%0d want 2 matching writes", wq.size()); end
    total++; if (rq.size() !== 7 || hit_count !== 7'd1) begin bad++; $display("FAIL rmid_counts got r=%0d h=%0d want 7 1", rq.size(), hit_count); end
  endtask

`ifdef COLLISION_TIMEOUT_EN
  task automatic test_timeout();
    logic signed [7:0] ex, ey;
    fill(3);
    silent = 1'b1;
    run_sweep(1, 3, 0, ok);
    silent = 1'b0;
    ex = pmem_x[0] + pmem_dx[0]; ey = pmem_y[0] + pmem_dy[0];
    total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL tmo_flag got %b want 1", timeout_flag); end
    total++; if (wq.size() !== 1 || wq[0].data !== {ex, ey, pmem_vx[0], pmem_vy[0]}) begin bad++; $display("FAIL tmo_write got n=%0d want 1 free write", wq.size()); end
    total++; if (busy_cyc !== 5 + 3 * (3 + 8)) begin bad++; $display("FAIL tmo_cycles got %0d want %0d", busy_cyc, 5 + 3 * 11); end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk_in);
    test_reset();
    rst_in = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_direct_hit();
    test_wrap();
    test_three_points();
    test_few_verts();
    test_zero_points();
    test_random();
    test_reset_mid();
`ifdef COLLISION_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/collision_sweep.md
# collision_sweep

Sequencer that shares one `collision_new_values` datapath across every soft-body point and every obstacle edge in a frame. On a `start` pulse it walks the point RAM and, for each point, walks the closed obstacle polygon edge by edge. It issues one request per edge to the collision unit and stops the edge loop at the first reported collision. It then writes the resolved position and velocity back to the point RAM and, after the last point, pulses `done`.

## Interface
- `POSITION_SIZE`, 8, signed position/displacement width
- `VELOCITY_SIZE`, 8, signed velocity width
- `MAX_POINTS`, 64, point RAM depth; `PA = $clog2(MAX_POINTS)`
- `MAX_VERTS`, 16, vertex RAM depth; `VA = $clog2(MAX_VERTS)`
- `TIMEOUT_CYCLES`, 256, watchdog limit, used only with `COLLISION_TIMEOUT_EN`
- `clk_in` in 1: single clock
- `rst_in` in 1: asynchronous, active-high reset
- `start` in 1: begins a sweep; ignored while `busy`
- `num_points` in PA+1: number of points, sampled at `start`
- `num_verts` in VA+1: polygon vertex count, sampled at `start`
- `pt_rd_addr` out PA: point RAM read address
- `pt_pos_x`, `pt_pos_y`, `pt_dx`, `pt_dy` in POSITION_SIZE: point read data, valid 1 cycle after the address
- `pt_vel_x`, `pt_vel_y` in VELOCITY_SIZE: point read data, valid 1 cycle after the address
- `pt_wr_en` out 1: one-cycle write strobe
- `pt_wr_addr` out PA: write address
- `pt_wr_x`, `pt_wr_y` out POSITION_SIZE: resolved position
- `pt_wr_vx`, `pt_wr_vy` out VELOCITY_SIZE: resolved velocity
- `vt_rd_addr` out VA: vertex RAM address
- `vt_x`, `vt_y` in POSITION_SIZE: vertex data, 1-cycle read latency
- `col_valid_out` out 1: one-cycle request pulse to the collision unit
- `col_v1_x`, `col_v1_y`, `col_v2_x`, `col_v2_y`, `col_pos_x`, `col_pos_y`, `col_dx`, `col_dy` out POSITION_SIZE: request operands
- `col_vel_x`, `col_vel_y` out VELOCITY_SIZE: request operands
- `col_valid_in` in 1: response from the collision unit
- `col_hit` in 1: collision flag from the response
- `col_x_new`, `col_y_new` in POSITION_SIZE: response position
- `col_vx_new`, `col_vy_new` in VELOCITY_SIZE: response velocity
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse at the end of a sweep
- `hit_count` out PA+1: number of points that collided in the last sweep
- `timeout_flag` out 1: sticky; set by a watchdog expiry, cleared by `start`

## Operation
- States: IDLE → PT_ADDR → PT_CAP → V0_ADDR → V0_CAP → VN_ADDR → VN_CAP → ISSUE → WAIT → (VN_ADDR | WRITE) → next point or DONE → IDLE.
- PT_ADDR / PT_CAP: drive `pt_rd_addr = p`, then capture all six point fields.
- V0_ADDR / V0_CAP: read vertex 0 into both `first` and `prev`.
- Edge loop, edge `e` = 0 … `num_verts`−1:
  - VN_ADDR reads vertex `(e+1) mod num_verts`; VN_CAP latches it as `cur`.
  - The last edge wraps to vertex 0 and uses the cached `first`. Its read is still issued, and the returned data is discarded.
- ISSUE: pulse `col_valid_out` with `v1 = prev`, `v2 = cur`, plus the captured point fields. Operands stay stable until the response arrives.
- WAIT: on `col_valid_in`:
  - if `col_hit`, latch the response, increment `hit_count`, go to WRITE;
  - otherwise set `prev <= cur`, `e++`, and go to VN_ADDR, or to WRITE after the last edge.
- WRITE: pulse `pt_wr_en` at `pt_wr_addr = p`.
  - Hit: write the response values.
  - No hit: write `pos + d`, truncated to POSITION_SIZE with two's-complement wrap, and leave velocity unchanged.
- `num_verts < 2`: skip all vertex reads and requests; every point takes the no-hit path.
- `num_points == 0`: go straight from IDLE to DONE, with no RAM access.
- `col_valid_in` outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `hit_count` 0, `timeout_flag` 0.
- Reset mid-sweep returns to IDLE immediately, with no write and no `done`. A late `col_valid_in` after reset is ignored.
- `start` in IDLE: `busy` rises on the next cycle and `hit_count` clears to 0.
- Per-point cycles = 5 + Σ over edges tested of (3 + Lₑ), where Lₑ is the number of WAIT cycles up to and including `col_valid_in`.
- `done` is asserted in the cycle after the last WRITE. `busy` falls in that same cycle.
- `start` coincident with `done` is ignored.

## Configuration
- `COLLISION_TIMEOUT_EN` defined:
  - a WAIT counter runs; if it reaches TIMEOUT_CYCLES without `col_valid_in`, the edge is treated as no-hit;
  - `timeout_flag` is set and the sweep continues.
- `COLLISION_TIMEOUT_EN` undefined: WAIT has no bound, and `timeout_flag` is tied to 0.

## Test plan
- 1 point at (10,10), d=(0,−20), square (0,0)(40,0)(40,40)(0,40), unit model hits on edge 0 returning (10,2), v=(3,−4) → exactly one request; write of (10,2,3,−4) at address 0; `hit_count` = 1.
- Same point with d=(0,5) and no hits → 4 requests; the 4th has `v1` = (0,40) and `v2` = (0,0) (wrap); write of (10,15) with the original velocity.
- `num_points` = 3 and the hit lands on the 2nd edge of point 1 → point 1 stops after 2 requests; 3 writes at addresses 0, 1, 2 in order; `done` pulses once.
- `num_verts` = 1, `num_points` = 2 → no `col_valid_out`; two free-motion writes; pos 127 + d 1 wraps to −128.
- Reset asserted during WAIT, then a `col_valid_in` pulse → no write, no `done`; a subsequent `start` runs a clean sweep.
- With `COLLISION_TIMEOUT_EN` and TIMEOUT_CYCLES = 8, the unit never responds → each edge is abandoned after 8 cycles; `timeout_flag` = 1; no-hit write performed.
